// File: rtl/exe_mdu_pkg.sv
// Shared constants for the EXE-stage multiply/divide unit: op bit indices,
// FSM state encoding and reset values.
package exe_mdu_pkg;

    // One-hot op vector bit positions
    localparam int MDU_MULT  = 0;
    localparam int MDU_MULTU = 1;
    localparam int MDU_DIV   = 2;
    localparam int MDU_DIVU  = 3;
    localparam int MDU_MFHI  = 4;
    localparam int MDU_MFLO  = 5;
    localparam int MDU_MTHI  = 6;
    localparam int MDU_MTLO  = 7;
    localparam int MDU_OP_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Reset values
    localparam mdu_state_e            INI_STATE = ST_IDLE;
    localparam logic [MDU_OP_W-1:0]   INI_OP    = '0;

    // State an accepted op enters: MF/MT (and empty ops) complete at once
    function automatic mdu_state_e op_entry_state(input logic [MDU_OP_W-1:0] op);
        if (op[MDU_MULT] | op[MDU_MULTU])
            return ST_MUL;
        else if (op[MDU_DIV] | op[MDU_DIVU])
            return ST_DIV;
        else
            return ST_DONE;
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Iterative restoring divider. Cycle 0 takes operand magnitudes, cycles
// 1..XLEN produce one quotient bit each. Results hold until the next start.
module mdu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

    logic             busy_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             signed_reg;
    logic [XLEN-1:0]  a_reg;
    logic [XLEN-1:0]  b_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [XLEN-1:0]  rem_reg;
    logic [XLEN-1:0]  quo_reg;
    logic [XLEN-1:0]  dvs_reg;

    logic             a_neg;
    logic             b_neg;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    assign a_neg   = signed_reg & a_reg[XLEN-1];
    assign b_neg   = signed_reg & b_reg[XLEN-1];
    assign shifted = {rem_reg, quo_reg[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_reg};
    assign done    = busy_reg & (cnt_reg == LAST_CNT);

    // Divide by zero bypasses the sign fix: all-ones quotient, raw dividend
    assign quotient  = (b_reg == '0) ? '1    : (neg_q_reg ? -quo_reg : quo_reg);
    assign remainder = (b_reg == '0) ? a_reg : (neg_r_reg ? -rem_reg : rem_reg);

    // Operand capture, magnitude setup and one restoring step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            signed_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            signed_reg <= is_signed;
            a_reg      <= dividend;
            b_reg      <= divisor;
        end else if (abort) begin
            busy_reg   <= 1'b0;
        end else if (busy_reg) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == '0) begin
                quo_reg   <= a_neg ? -a_reg : a_reg;
                dvs_reg   <= b_neg ? -b_reg : b_reg;
                rem_reg   <= '0;
                neg_q_reg <= a_neg ^ b_neg;
                neg_r_reg <= a_neg;
            end else begin
                if (!diff[XLEN]) begin
                    rem_reg <= diff[XLEN-1:0];
                    quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
                end else begin
                    rem_reg <= shifted[XLEN-1:0];
                    quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
                end
                if (cnt_reg == LAST_CNT)
                    busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exe_mdu.sv
// EXE-stage multiply/divide unit with valid/allowin handshake. HI/LO are
// architectural and only change when a result is handed downstream.
module exe_mdu
    import exe_mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_in,
    input  logic                in_valid,
    output logic                in_allowin,
    input  logic [MDU_OP_W-1:0] op_in,
    input  logic [XLEN-1:0]     src0_in,
    input  logic [XLEN-1:0]     src1_in,
    output logic                out_valid,
    input  logic                out_allowin,
    output logic [XLEN-1:0]     rdata_out,
    output logic                busy_out,
    output logic [XLEN-1:0]     hi_out,
    output logic [XLEN-1:0]     lo_out
);

    mdu_state_e          state_reg, state_next;
    logic [2:0]          mul_cnt_reg;
    logic [MDU_OP_W-1:0] op_reg;
    logic [XLEN-1:0]     src0_reg, src1_reg;
    logic [XLEN-1:0]     hi_reg, lo_reg;
    logic [XLEN-1:0]     hi_next, lo_next;
    logic                accept, handoff;
    logic                mul_signed;
    logic [2*XLEN-1:0]   mul_ext0, mul_ext1, mul_prod, mul_result;
    logic                div_done;
    logic [XLEN-1:0]     div_quo, div_rem;

    assign in_allowin = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_allowin);
    assign out_valid  = (state_reg == ST_DONE);
    assign busy_out   = (state_reg == ST_MUL) | (state_reg == ST_DIV);
    assign accept     = in_valid & in_allowin & ~flush_in;
    assign handoff    = out_valid & out_allowin & ~flush_in;
    assign hi_out     = hi_reg;
    assign lo_out     = lo_reg;

    // HI/LO are stable during DONE, so reads need no bypass
    assign rdata_out = !out_valid          ? '0     :
                       op_reg[MDU_MFHI]    ? hi_reg :
                       op_reg[MDU_MFLO]    ? lo_reg : '0;

    // Next state: flush wins, then accept (also covers accept during handoff)
    always_comb begin
        state_next = state_reg;
        if (flush_in) begin
            state_next = ST_IDLE;
        end else if (accept) begin
            state_next = op_entry_state(op_in);
        end else begin
            case (state_reg)
                ST_MUL:  if (mul_cnt_reg == 3'(MUL_STAGES - 1)) state_next = ST_DONE;
                ST_DIV:  if (div_done) state_next = ST_DONE;
                ST_DONE: if (handoff) state_next = ST_IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    // State register, op/operand capture and multiply latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= INI_STATE;
            op_reg      <= INI_OP;
            src0_reg    <= '0;
            src1_reg    <= '0;
            mul_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg      <= op_in;
                src0_reg    <= src0_in;
                src1_reg    <= src1_in;
                mul_cnt_reg <= '0;
            end else if (state_reg == ST_MUL) begin
                mul_cnt_reg <= mul_cnt_reg + 3'd1;
            end
        end
    end

    // Multiplier: sign-extend to full width so one '*' serves MULT and MULTU
    assign mul_signed = op_reg[MDU_MULT];
    assign mul_ext0   = {{XLEN{mul_signed & src0_reg[XLEN-1]}}, src0_reg};
    assign mul_ext1   = {{XLEN{mul_signed & src1_reg[XLEN-1]}}, src1_reg};
    assign mul_prod   = mul_ext0 * mul_ext1;

    genvar gi;
    for (gi = 0; gi < MUL_STAGES; gi++) begin : g_mul
        logic [2*XLEN-1:0] stage_q;
        if (gi == 0) begin : g_first
            // First retiming stage captures the raw product while in MUL
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    stage_q <= '0;
                else if (state_reg == ST_MUL)
                    stage_q <= mul_prod;
            end
        end else begin : g_rest
            // Later stages shift only in MUL so DONE holds the product
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    stage_q <= '0;
                else if (state_reg == ST_MUL)
                    stage_q <= g_mul[gi-1].stage_q;
            end
        end
    end
    assign mul_result = g_mul[MUL_STAGES-1].stage_q;

    mdu_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (flush_in),
        .start     (accept & (op_in[MDU_DIV] | op_in[MDU_DIVU])),
        .is_signed (op_in[MDU_DIV]),
        .dividend  (src0_in),
        .divisor   (src1_in),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Commit values: unchanged unless the result is handed off this cycle
    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        if (handoff) begin
            if (op_reg[MDU_MULT] | op_reg[MDU_MULTU]) begin
                hi_next = mul_result[2*XLEN-1:XLEN];
                lo_next = mul_result[XLEN-1:0];
            end else if (op_reg[MDU_DIV] | op_reg[MDU_DIVU]) begin
                hi_next = div_rem;
                lo_next = div_quo;
            end else begin
                if (op_reg[MDU_MTHI]) hi_next = src0_reg;
                if (op_reg[MDU_MTLO]) lo_next = src0_reg;
            end
        end
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
        end
    end

endmodule

// File: tb/tb_exe_mdu.sv
// Scoreboard bench for exe_mdu: driver pushes expected results, a monitor
// pops and checks latency, rdata stability, rdata and committed HI/LO.
module tb_exe_mdu;

    localparam logic [7:0] OP_MULT  = 8'h01;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_DIVU  = 8'h08;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h20;
    localparam logic [7:0] OP_MTHI  = 8'h40;
    localparam logic [7:0] OP_MTLO  = 8'h80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_allowin;
    logic [7:0]  op_in = '0;
    logic [31:0] src0_in = '0;
    logic [31:0] src1_in = '0;
    logic        out_valid;
    logic        out_allowin = 1'b1;
    logic [31:0] rdata_out;
    logic        busy_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    string       sb_name[$];
    exp_t        mon_e;
    string       mon_n;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b1;
    bit          started = 1'b0;
    logic [31:0] held_rd;

    exe_mdu #(.XLEN(32), .MUL_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_in    (flush_in),
        .in_valid    (in_valid),
        .in_allowin  (in_allowin),
        .op_in       (op_in),
        .src0_in     (src0_in),
        .src1_in     (src1_in),
        .out_valid   (out_valid),
        .out_allowin (out_allowin),
        .rdata_out   (rdata_out),
        .busy_out    (busy_out),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Offer one op (called just after a rising edge); returns just after its accept edge
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] rd, input logic [31:0] hi,
                         input logic [31:0] lo, input int lat, input string name);
        int n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        op_in    = op;
        src0_in  = a;
        src1_in  = b;
        @(negedge clk);
        while (!in_allowin && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_allowin) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout actual=in_allowin_low required=in_allowin_high", name);
        end else if (push) begin
            e.rd = rd; e.hi = hi; e.lo = lo; e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
            sb_name.push_back(name);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_in    = '0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", sb.size());
        end
    endtask

    // Monitor: checks every presented result against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && mon_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 rdata=%h", rdata_out);
                end else begin
                    if (!started) begin
                        started = 1'b1;
                        held_rd = rdata_out;
                        checks++;
                        if (cyc - sb[0].acc + 1 != sb[0].lat) begin
                            errors++;
                            $display("FAIL %s_latency actual=%0d required=%0d", sb_name[0],
                                     cyc - sb[0].acc + 1, sb[0].lat);
                        end
                    end else begin
                        chk({sb_name[0], "_rdata_stable"}, rdata_out, held_rd);
                    end
                    if (out_allowin && !flush_in) begin
                        mon_e = sb.pop_front();
                        mon_n = sb_name.pop_front();
                        chk({mon_n, "_rdata"}, rdata_out, mon_e.rd);
                        @(posedge clk);
                        #1;
                        chk({mon_n, "_hi"}, hi_out, mon_e.hi);
                        chk({mon_n, "_lo"}, lo_out, mon_e.lo);
                        $display("txn %s rdata=%h hi=%h lo=%h", mon_n, mon_e.rd, hi_out, lo_out);
                        started = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy_out}, 32'd0);
        chk("rst_allowin", {31'b0, in_allowin}, 32'd1);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Signed multiply with delayed handoff, then MFHI
        out_allowin = 1'b0;
        issue(OP_MULT, 32'd7, 32'hFFFFFFF9, 1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFCF, 3, "mult");
        repeat (2) @(posedge clk);
        #1;
        chk("mult_valid_up", {31'b0, out_valid}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("mult_valid_held", {31'b0, out_valid}, 32'd1);
        out_allowin = 1'b1;
        wait_drain();
        issue(OP_MFHI, 32'd0, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFCF, 1, "mfhi");
        wait_drain();

        // Divides: sign fix, unsigned, divide by zero, signed overflow
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, "div_neg");
        wait_drain();
        issue(OP_DIVU, 32'hFFFFFFF9, 32'd2, 1, 32'd0, 32'd1, 32'h7FFFFFFC, 34, "divu");
        wait_drain();
        issue(OP_DIVU, 32'd5, 32'd0, 1, 32'd0, 32'd5, 32'hFFFFFFFF, 34, "divu_zero");
        wait_drain();
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'd0, 32'h80000000, 34, "div_ovf");
        wait_drain();

        // Known HI/LO, then flush in the middle of a divide
        issue(OP_MTHI, 32'h0000AAAA, 32'd0, 1, 32'd0, 32'h0000AAAA, 32'h80000000, 1, "mthi");
        issue(OP_MTLO, 32'h00005555, 32'd0, 1, 32'd0, 32'h0000AAAA, 32'h00005555, 1, "mtlo");
        wait_drain();
        issue(OP_DIV, 32'd100, 32'd3, 0, 32'd0, 32'd0, 32'd0, 34, "div_flushed");
        repeat (10) @(posedge clk);
        #1;
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        chk("fdiv_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fdiv_allowin", {31'b0, in_allowin}, 32'd1);
        chk("fdiv_busy", {31'b0, busy_out}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("fdiv_hi", hi_out, 32'h0000AAAA);
        chk("fdiv_lo", lo_out, 32'h00005555);

        // Flush coinciding with handoff and a new offer
        mon_en = 1'b0;
        out_allowin = 1'b0;
        issue(OP_MTLO, 32'h00001234, 32'd0, 0, 32'd0, 32'd0, 32'd0, 1, "mtlo_flushed");
        chk("fh_done_reached", {31'b0, out_valid}, 32'd1);
        flush_in    = 1'b1;
        out_allowin = 1'b1;
        in_valid    = 1'b1;
        op_in       = OP_MTHI;
        src0_in     = 32'h00007777;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        in_valid = 1'b0;
        op_in    = '0;
        chk("fh_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fh_allowin", {31'b0, in_allowin}, 32'd1);
        chk("fh_hi", hi_out, 32'h0000AAAA);
        chk("fh_lo", lo_out, 32'h00005555);
        repeat (3) @(posedge clk);
        #1;
        chk("fh_no_accept", {31'b0, out_valid}, 32'd0);
        chk("fh_hi_later", hi_out, 32'h0000AAAA);
        mon_en = 1'b1;

        // Back-to-back MF/MT stream
        issue(OP_MTHI, 32'd1, 32'd0, 1, 32'd0, 32'd1, 32'h00005555, 1, "s_mthi");
        issue(OP_MTLO, 32'd2, 32'd0, 1, 32'd0, 32'd1, 32'd2, 1, "s_mtlo");
        issue(OP_MFHI, 32'd0, 32'd0, 1, 32'd1, 32'd1, 32'd2, 1, "s_mfhi");
        issue(OP_MFLO, 32'd0, 32'd0, 1, 32'd2, 32'd1, 32'd2, 1, "s_mflo");
        wait_drain();

        // Asynchronous reset in the middle of a multiply
        mon_en = 1'b0;
        issue(OP_MULT, 32'd3, 32'd4, 0, 32'd0, 32'd0, 32'd0, 3, "mult_reset");
        chk("mr_busy_before", {31'b0, busy_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mr_busy", {31'b0, busy_out}, 32'd0);
        chk("mr_allowin", {31'b0, in_allowin}, 32'd1);
        chk("mr_rdata", rdata_out, 32'd0);
        chk("mr_hi", hi_out, 32'd0);
        chk("mr_lo", lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_mdu.md
# exe_mdu

Parametrised multiply/divide unit for the EXE stage of the in-order MIPS pipeline. It replaces the single-width `div_tready` / `mult_div_op` sideband with a self-contained unit that has:
- the standard valid/allowin stage handshake;
- a multi-cycle pipelined multiplier;
- an iterative restoring divider;
- architectural HI/LO registers.

HI/LO commit only when the result is handed downstream, so a WB flush (`ClrStpJmp`) leaves the architectural state untouched.

## Interface
Parameters:
- XLEN, 32, operand/HI/LO width (even, ≥8)
- MUL_STAGES, 2, multiplier latency in cycles (1..4)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_in  in  1  WB flush (`ClrStpJmp`); aborts any in-flight op
- in_valid  in  1  op offered by ID
- in_allowin  out  1  unit can accept an op this cycle
- op_in  in  8  one-hot {0:MULT, 1:MULTU, 2:DIV, 3:DIVU, 4:MFHI, 5:MFLO, 6:MTHI, 7:MTLO}
- src0_in  in  XLEN  rs value (dividend / multiplicand / MT data)
- src1_in  in  XLEN  rt value (divisor / multiplier)
- out_valid  out  1  result ready for MEM
- out_allowin  in  1  MEM can take the result
- rdata_out  out  XLEN  MFHI/MFLO read value; 0 for other ops
- busy_out  out  1  MUL or DIV state active
- hi_out, lo_out  out  XLEN  committed HI/LO

## Operation
States:
- IDLE
- MUL: counter 0..MUL_STAGES-1
- DIV: counter 0..XLEN
- DONE: result held in hi_nx/lo_nx/rdata_r

Handshake and flow:
- in_allowin = (state==IDLE) | (state==DONE & out_allowin).
- Accept = in_valid & in_allowin & !flush_in. The op and operands are latched on accept.
- Accepted MF/MT ops go straight to DONE. MULT/MULTU go to MUL. DIV/DIVU go to DIV.
- An op accepted while DONE is being handed off enters its next state directly; there is no IDLE bubble.
- out_valid = (state==DONE). Handoff = out_valid & out_allowin & !flush_in.

Commit:
- HI/LO are written only at handoff:
  - MULT/MULTU: {HI,LO} = product
  - DIV/DIVU: HI = remainder, LO = quotient
  - MTHI writes HI; MTLO writes LO
  - MFHI/MFLO write nothing
- A DONE state reached without handoff keeps HI/LO unchanged.

Reads:
- MFHI/MFLO read hi_r/lo_r in the DONE cycle, combinationally.
- In-order acceptance guarantees any preceding MULT/DIV has already committed, so no bypass path is needed.

Flush:
- flush_in in any state forces IDLE next cycle.
- No HI/LO write, out_valid low next cycle, in_allowin high next cycle.
- Flush has priority over accept and over handoff in the same cycle.

Multiply:
- Signed (MULT) or unsigned (MULTU) 2·XLEN-bit product.
- Computed over MUL_STAGES register stages, then DONE.

Divide:
- Restoring divide on operand magnitudes. Cycle 0 computes the absolute values and sign flags; cycles 1..XLEN each perform one quotient bit.
- Sign fix while entering DONE:
  - quotient is negative if the operand signs differ;
  - remainder takes the dividend's sign.
- Divide by zero:
  - quotient = all ones;
  - remainder = dividend;
  - no exception;
  - same latency as a normal divide.
- Overflow case, signed −2^(XLEN−1) / −1: quotient = −2^(XLEN−1), remainder = 0.

## Timing
Reset values:
- state = IDLE
- out_valid = 0, busy_out = 0
- rdata_out = 0
- hi_out = 0, lo_out = 0
- in_allowin = 1

Latency, accept edge to out_valid:
- MF/MT: 1 cycle
- MULT/MULTU: MUL_STAGES+1 cycles
- DIV/DIVU: XLEN+2 cycles (34 at XLEN=32)

Backpressure:
- DONE holds out_valid and rdata_out stable indefinitely while out_allowin is low.
- Back-to-back ops at full throughput are possible only for MF/MT: one per cycle with out_allowin held high.

Reset:
- rst_n low mid-operation clears everything immediately (asynchronously), including HI/LO.

## Structure
- `defines.vh` holds:
  - the op bit indices (MDU_MULT..MDU_MTLO);
  - the state encoding;
  - the reset values, in the codebase `ini_*` style.
- One sub-module, `mdu_div_iter`: the iterative divider core, with start, operands, signed flag, done, quotient and remainder.
- The multiplier is inline. It is a `*` with a retiming shift register of MUL_STAGES stages.

## Test plan
- **MULT, signed product, delayed handoff.** MULT with src0=7, src1=0xFFFFFFF9 (−7); hold out_allowin low for 5 cycles, then raise it.
  - out_valid after 3 cycles and held stable while out_allowin is low.
  - At handoff: HI=0xFFFFFFFF, LO=0xFFFFFFCF.
  - Then MFHI → rdata_out=0xFFFFFFFF, 1 cycle after accept.
- **DIV sign fix.** DIV with −7 / 2 → out_valid exactly 34 cycles after accept; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU with 0xFFFFFFF9 / 2 → LO=0x7FFFFFFC, HI=1.
- **Divide boundary cases.**
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Flush mid-divide.** Set HI/LO via MTHI 0xAAAA / MTLO 0x5555. Start DIV, assert flush_in on divide cycle 10.
  - IDLE and in_allowin=1 next cycle.
  - HI/LO remain 0xAAAA/0x5555.
  - No out_valid pulse.
- **Flush at handoff.** DONE with out_allowin=1 and flush_in=1 in the same cycle → no commit, no accept of the concurrent in_valid op.
- **MF/MT stream and reset.** Stream MTHI 1, MTLO 2, MFHI, MFLO with out_allowin=1 → one result per cycle; reads return 1 then 2.
  - Then pulse rst_n low mid-MULT → all outputs are at their reset values before the next clock edge.
